// File: rtl/palette_loader.sv
// Assembles downloaded byte pairs into RGB555 palette entries and writes them to palette RAM.
// Define PALETTE_LOADER_WINDOW_EN to restrict RAM writes to the blanking window.
module palette_loader #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [7:0]  dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_wait,
   input  logic        blank,
   output logic        load_color,
   output logic [5:0]  load_color_index,
   output logic [14:0] load_color_data,
   output logic        pal_valid,
   output logic        overflow
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0]    lo;
   logic          ent_valid;
   logic [5:0]    ent_index;
   logic [14:0]   ent_data;
   logic [20:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [20:0]   head;
   logic [5:0]    held_index;
   logic [14:0]   held_data;
   logic [63:0]   mask;
   logic [63:0]   mask_next;
   logic          dl_active_q;
   logic          active_rise;
   logic          window;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push;

   always_comb begin
`ifdef PALETTE_LOADER_WINDOW_EN
      window = blank;
`else
      // Video is held off in this build, so the write window is always open.
      window = blank | 1'b1;
`endif
      head        = fifo_mem[rd_ptr];
      empty       = (count == '0);
      full        = (count == CW'(FIFO_DEPTH));
      pop         = !empty && window;
      push        = ent_valid && !full;
      active_rise = dl_active && !dl_active_q;
      count_next  = count + CW'(push) - CW'(pop);

      load_color       = pop;
      load_color_index = pop ? head[20:15] : held_index;
      load_color_data  = pop ? head[14:0]  : held_data;

      // A pop in the same cycle as a new download start still counts toward the fresh mask.
      mask_next = active_rise ? '0 : mask;
      if (pop) begin
         mask_next[head[20:15]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         fifo_mem[wr_ptr] <= {ent_index, ent_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lo          <= '0;
         ent_valid   <= 1'b0;
         ent_index   <= '0;
         ent_data    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         held_index  <= '0;
         held_data   <= '0;
         mask        <= '0;
         dl_active_q <= 1'b0;
         dl_wait     <= 1'b0;
         pal_valid   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         ent_valid <= 1'b0;
         if (dl_wr && !dl_addr[7]) begin
            if (!dl_addr[0]) begin
               lo <= dl_data;
            end else begin
               ent_valid <= 1'b1;
               ent_index <= dl_addr[6:1];
               ent_data  <= {dl_data[6:0], lo};
               lo        <= '0;
            end
         end

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            held_index <= head[20:15];
            held_data  <= head[14:0];
         end
         count       <= count_next;
         mask        <= mask_next;
         dl_active_q <= dl_active;
         dl_wait     <= (count >= CW'(FIFO_DEPTH - 1));
         pal_valid   <= (&mask_next) && (count_next == '0);
         overflow    <= (overflow && !active_rise) || (ent_valid && full);
      end
   end

endmodule

// File: tb/tb_palette_loader.sv
// Randomised and directed bench for palette_loader, checked every cycle against a queue-based model.
module tb_palette_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        dl_active;
   logic        dl_wr;
   logic [7:0]  dl_addr;
   logic [7:0]  dl_data;
   logic        dl_wait;
   logic        blank;
   logic        load_color;
   logic [5:0]  load_color_index;
   logic [14:0] load_color_data;
   logic        pal_valid;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_lo = '0;
   bit          m_pend = 0;
   logic [20:0] m_pend_entry = '0;
   logic [20:0] m_fifo[$];
   bit          m_overflow = 0;
   bit          m_dl_wait = 0;
   bit          m_pal_valid = 0;
   bit          m_prev_active = 0;
   logic [63:0] m_mask = '0;
   logic [20:0] m_held = '0;
   logic [20:0] obs[$];

   palette_loader #(.FIFO_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .dl_active        (dl_active),
      .dl_wr            (dl_wr),
      .dl_addr          (dl_addr),
      .dl_data          (dl_data),
      .dl_wait          (dl_wait),
      .blank            (blank),
      .load_color       (load_color),
      .load_color_index (load_color_index),
      .load_color_data  (load_color_data),
      .pal_valid        (pal_valid),
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Compare on the falling edge, then advance the model by the rising edge that follows.
   always @(negedge clk) begin
      bit          win;
      bit          pop;
      bit          full;
      bit          rise;
      int          sz;
      logic [20:0] head;
`ifdef PALETTE_LOADER_WINDOW_EN
      win = blank;
`else
      win = 1'b1;
`endif
      sz   = m_fifo.size();
      pop  = (sz > 0) && win;
      head = pop ? m_fifo[0] : m_held;
      checkOutput("load_color", load_color, pop);
      checkOutput("load_color_index", load_color_index, head[20:15]);
      checkOutput("load_color_data", load_color_data, head[14:0]);
      checkOutput("dl_wait", dl_wait, m_dl_wait);
      checkOutput("pal_valid", pal_valid, m_pal_valid);
      checkOutput("overflow", overflow, m_overflow);
      if (load_color) obs.push_back({load_color_index, load_color_data});

      if (!reset_n) begin
         m_lo = '0; m_pend = 0; m_fifo.delete(); m_overflow = 0; m_dl_wait = 0;
         m_pal_valid = 0; m_prev_active = 0; m_mask = '0; m_held = '0;
      end else begin
         rise = dl_active && !m_prev_active;
         full = (sz == DEPTH);
         if (rise) begin
            m_mask = '0;
            m_overflow = 0;
         end
         if (pop) begin
            m_held = m_fifo.pop_front();
            m_mask[m_held[20:15]] = 1'b1;
         end
         if (m_pend) begin
            if (full) m_overflow = 1;
            else m_fifo.push_back(m_pend_entry);
         end
         m_dl_wait = (sz >= DEPTH - 1);
         m_pal_valid = (&m_mask) && (m_fifo.size() == 0);
         m_pend = 0;
         if (dl_wr && dl_addr < 8'd128) begin
            if (!dl_addr[0]) begin
               m_lo = dl_data;
            end else begin
               m_pend = 1;
               m_pend_entry = {dl_addr[6:1], dl_data[6:0], m_lo};
               m_lo = '0;
            end
         end
         m_prev_active = dl_active;
      end
   end

   task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data);
      dl_wr   = wr;
      dl_addr = addr;
      dl_data = data;
      @(posedge clk);
      #1;
      dl_wr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic sendEntry(input int idx, input logic [14:0] val, input bit honor_wait);
      int   guard;
      logic b7;
      guard = 0;
      while (honor_wait && dl_wait && guard < 100) begin
         blank = 1'b1;
         idle(1);
         guard++;
      end
      if (guard >= 100) begin
         checks++;
         errors++;
         $display("[TB] FAIL dl_wait_timeout actual=stuck required=released");
      end
      b7 = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, 8'(2 * idx), val[7:0]);
      applyStimulus(1'b1, 8'(2 * idx + 1), {b7, val[14:8]});
   endtask

   initial begin
      logic [20:0] e;
      logic [63:0] seen;
      reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0; blank = 1'b0;
      @(posedge clk); #1;
      idle(2);
      reset_n = 1'b1;
      checkOutput("reset_load_color", load_color, 0);
      checkOutput("reset_pal_valid", pal_valid, 0);

      // Single entry: addr 0x0A=0x34, 0x0B=0x7F
      dl_active = 1'b1;
      blank = 1'b1;
      idle(2);
      obs.delete();
      applyStimulus(1'b1, 8'h0A, 8'h34);
      applyStimulus(1'b1, 8'h0B, 8'h7F);
      idle(4);
      e = (obs.size() > 0) ? obs[0] : '1;
      checkOutput("single_count", obs.size(), 1);
      checkOutput("single_index", e[20:15], 5);
      checkOutput("single_data", e[14:0], 15'h7F34);

      // Entries 0..2 held back while the window is closed
      blank = 1'b0;
      obs.delete();
      for (int k = 0; k < 3; k++) sendEntry(k, 15'($urandom), 1'b0);
      idle(4);
`ifdef PALETTE_LOADER_WINDOW_EN
      checkOutput("blocked_count", obs.size(), 0);
`endif
      blank = 1'b1;
      idle(6);
      checkOutput("window_count", obs.size(), 3);
      for (int k = 0; k < 3; k++) begin
         e = (obs.size() > k) ? obs[k] : '1;
         checkOutput("window_order", e[20:15], k);
      end

      // Overflow: five entries into a depth-4 FIFO, ignoring dl_wait
      blank = 1'b0;
      obs.delete();
      for (int k = 0; k < 3; k++) sendEntry(10 + k, 15'($urandom), 1'b0);
      idle(2);
`ifdef PALETTE_LOADER_WINDOW_EN
      checkOutput("wait_after_third", dl_wait, 1);
`endif
      for (int k = 3; k < 5; k++) sendEntry(10 + k, 15'($urandom), 1'b0);
      idle(2);
`ifdef PALETTE_LOADER_WINDOW_EN
      checkOutput("overflow_set", overflow, 1);
`endif
      blank = 1'b1;
      idle(8);
`ifdef PALETTE_LOADER_WINDOW_EN
      checkOutput("overflow_writes", obs.size(), 4);
`endif

      // Full palette with an intermittent window, honouring dl_wait
      dl_active = 1'b0;
      idle(1);
      dl_active = 1'b1;
      obs.delete();
      for (int i = 0; i < 64; i++) begin
         blank = ($urandom_range(0, 3) != 0);
         sendEntry(i, 15'($urandom), 1'b1);
      end
      blank = 1'b1;
      idle(10);
      checkOutput("palette_writes", obs.size(), 64);
      seen = '0;
      foreach (obs[k]) seen[obs[k][20:15]] = 1'b1;
      checkOutput("palette_cover_lo", seen[31:0], 32'hFFFF_FFFF);
      checkOutput("palette_cover_hi", seen[63:32], 32'hFFFF_FFFF);
      checkOutput("pal_valid_set", pal_valid, 1);
      checkOutput("palette_no_overflow", overflow, 0);
      dl_active = 1'b0;
      idle(1);
      dl_active = 1'b1;
      idle(2);
      checkOutput("pal_valid_cleared", pal_valid, 0);

      // Reset with buffered entries
      blank = 1'b0;
      obs.delete();
      sendEntry(20, 15'($urandom), 1'b0);
      sendEntry(21, 15'($urandom), 1'b0);
      idle(2);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      blank = 1'b1;
      idle(5);
`ifdef PALETTE_LOADER_WINDOW_EN
      checkOutput("reset_discard", obs.size(), 0);
`endif
      checkOutput("reset_mid_load_color", load_color, 0);
      checkOutput("reset_mid_dl_wait", dl_wait, 0);
      checkOutput("reset_mid_overflow", overflow, 0);
      checkOutput("reset_mid_pal_valid", pal_valid, 0);

      // Odd byte with no preceding even byte
      obs.delete();
      applyStimulus(1'b1, 8'h03, 8'h12);
      idle(4);
      e = (obs.size() > 0) ? obs[0] : '1;
      checkOutput("odd_count", obs.size(), 1);
      checkOutput("odd_index", e[20:15], 1);
      checkOutput("odd_data", e[14:0], 15'h1200);

      // Random traffic, including out-of-range addresses and occasional resets
      repeat (400) begin
         reset_n = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 31) == 0) dl_active = ~dl_active;
         blank = 1'($urandom_range(0, 1));
         applyStimulus(($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom));
      end
      reset_n = 1'b1;
      blank = 1'b1;
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/palette_loader.md
# palette_loader

Sequences writes of a downloaded 64-entry custom palette into the video block's palette RAM write port. It assembles the byte-wide download stream into 15-bit RGB555 entries and buffers them in a small FIFO. It issues RAM writes only inside the blanking window, so the write-address mux never steals the palette RAM from active pixels. It sits between the download/ioctl interface and the video block's `load_color*` inputs, and reports when a complete palette has landed.

## Interface
- `FIFO_DEPTH`, 4: entry FIFO depth; power of two, 2..16.
- `clk`  in  1: system clock; the video clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `dl_active`  in  1: palette download in progress.
- `dl_wr`  in  1: one-cycle byte strobe.
- `dl_addr`  in  8: byte address. Entry n is at bytes 2n (low) and 2n+1 (high).
- `dl_data`  in  8: download byte.
- `dl_wait`  out  1: backpressure to the downloader.
- `blank`  in  1: safe-write window (HBlank | VBlank, pix-clock aligned).
- `load_color`  out  1: palette RAM write strobe.
- `load_color_index`  out  6: palette RAM write address.
- `load_color_data`  out  15: palette RAM write data, {B[4:0],G[4:0],R[4:0]}.
- `pal_valid`  out  1: all 64 entries written since the last download start, and the FIFO is empty.
- `overflow`  out  1: sticky flag; an entry was dropped because the FIFO was full.

## Operation
- **Byte assembly**
  - `dl_wr` with `dl_addr` ≥ 128 is ignored.
  - `dl_wr` with even address: latch `lo <= dl_data`.
  - `dl_wr` with odd address: form entry {index = `dl_addr[6:1]`, data = {`dl_data[6:0]`, `lo`}}.
  - `dl_data[7]` of the high byte is discarded.
  - `lo` clears to 0 after every entry is formed. An odd byte without a preceding even byte uses `lo` = 0.
- **FIFO**
  - A formed entry is pushed on the next cycle.
  - If the FIFO is full at push time, the entry is dropped and `overflow` sets.
  - `overflow` clears only on reset or on a `dl_active` rising edge.
- **Issue**
  - Each cycle with FIFO non-empty and the window open: pop one entry and drive it on `load_color_index`/`load_color_data` with `load_color`=1 for exactly that cycle.
  - The window open condition is `blank`=1 when `PALETTE_LOADER_WINDOW_EN` is defined.
  - Back-to-back pops are allowed, one per cycle.
  - Push and pop in the same cycle: the count is unchanged.
- **Index/data hold**: `load_color_index`/`load_color_data` hold their last values when `load_color`=0.
- **Coverage**
  - A 64-bit mask sets bit n when entry n is popped.
  - The mask clears on a `dl_active` rising edge. That same cycle, an in-flight pop still sets its bit after the clear.
  - `pal_valid` = (&mask) & FIFO empty, registered.
- **End of download**: `dl_active` falling does not flush. Pending entries drain normally.
- **Backpressure**: `dl_wait` = (count ≥ `FIFO_DEPTH`−1), registered.

## Timing
- **Reset**: when `reset_n`=0 at a clk edge, the next state is:
  - `load_color`=0, index=0, data=0
  - `dl_wait`=0, `pal_valid`=0, `overflow`=0
  - FIFO empty, mask=0, `lo`=0
  - Reset mid-download discards buffered entries.
- **Latency**:
  - High byte strobe at cycle T → FIFO push at T+1.
  - Earliest `load_color` at T+2 with the window open.
  - If the window is closed, the write waits; the entry is held, never dropped.
- **Window edges**:
  - `blank` is sampled in the same cycle as the pop decision.
  - `blank` falling at cycle T means no `load_color` at T.
  - An entry that is already popped completes; it is never split.
- **`pal_valid`** rises 1 cycle after the pop of the last missing entry, provided the FIFO is then empty.
- **`dl_wait`** asserts 1 cycle after the count reaches `FIFO_DEPTH`−1. One further in-flight entry is always absorbed without overflow.

## Configuration
- **`PALETTE_LOADER_WINDOW_EN` defined**: pops are gated by `blank` as above.
- **Not defined**:
  - `blank` is ignored and entries issue whenever the FIFO is non-empty (minimum latency T+2).
  - Intended for loading while video is held in reset.
  - `dl_wait` and `overflow` behaviour are unchanged.

## Test plan
- **Single entry in window**: `blank`=1; bytes addr 0x0A=0x34, 0x0B=0x7F → one `load_color` pulse at T+2 with index=5, data=0x7F34 & 0x7FFF=0x7F34.
- **Blocked outside window**: `blank`=0; write entries 0..2 → no `load_color`. Raise `blank` → three consecutive pulses, indices 0,1,2 in order.
- **Overflow**: `blank`=0, depth 4.
  - `dl_wait`=1 after the 3rd entry.
  - Ignoring `dl_wait`, send a 5th entry → it is dropped and `overflow`=1.
  - Raise `blank` → exactly 4 writes.
- **Full palette**: `dl_active` rise; 128 bytes; `blank`=1 → 64 writes, then `pal_valid`=1. A new `dl_active` rise clears it to 0.
- **Reset mid-download**: 2 entries buffered with `blank`=0; `reset_n`=0 for 1 cycle → FIFO empty, no writes after `blank`=1, all outputs 0.
- **Odd-only byte**: addr 0x03=0x12 with no preceding even byte → data=0x1200, index=1.
